// File: rtl/clk_train_sequencer_pkg.sv
// Shared encodings for the clock-training sequencer: FSM states, sideband
// message codes and the all-lanes-passed result pattern.
package clk_train_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_SEND_START  = 4'd1,
      ST_WAIT_START  = 4'd2,
      ST_PATTERN     = 4'd3,
      ST_SEND_RESULT = 4'd4,
      ST_WAIT_RESULT = 4'd5,
      ST_EVAL        = 4'd6,
      ST_SEND_DONE   = 4'd7,
      ST_WAIT_DONE   = 4'd8,
      ST_PASS        = 4'd9,
      ST_FAIL        = 4'd10
   } state_t;

   localparam logic [1:0] MSG_NONE   = 2'b00;
   localparam logic [1:0] MSG_START  = 2'b01;
   localparam logic [1:0] MSG_RESULT = 2'b10;
   localparam logic [1:0] MSG_DONE   = 2'b11;

   localparam logic [2:0] RESULT_ALL_PASS = 3'b111;

   // Sideband message carried by a SEND_x state (also the response WAIT_x expects)
   function automatic logic [1:0] state_msg(input state_t s);
      case (s)
         ST_SEND_START,  ST_WAIT_START:  state_msg = MSG_START;
         ST_SEND_RESULT, ST_WAIT_RESULT: state_msg = MSG_RESULT;
         ST_SEND_DONE,   ST_WAIT_DONE:   state_msg = MSG_DONE;
         default:                        state_msg = MSG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/clk_train_sequencer_sb_req_holder.sv
// Sideband request register: valid/msg are loaded on entry to a SEND state
// and held until the sideband accepts them or the FSM leaves the state.
module clk_train_sequencer_sb_req_holder
   import clk_train_sequencer_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_load,
   input  logic [1:0] i_msg,
   input  logic       i_drop,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [1:0] o_msg
);

   logic       r_valid;
   logic [1:0] r_msg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_msg   <= MSG_NONE;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_msg   <= i_msg;
      end else begin
         r_valid <= r_valid & ~i_ready & ~i_drop;
      end
   end

   assign o_valid = r_valid;
   assign o_msg   = r_msg;

endmodule

// File: rtl/clk_train_sequencer.sv
// Mainband clock-training sequencer: runs pattern bursts on clock_generator,
// exchanges START/RESULT/DONE with the partner and retries failed results.
module clk_train_sequencer
   import clk_train_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int MAX_RETRY      = 3,
   parameter int TMR_W          = 10
) (
   input  logic       i_dig_clk,
   input  logic       i_rst,
   input  logic       i_enable,
   input  logic       i_ltsm_in_reset,
   output logic       o_start_clk_train,
   output logic       o_gen_stop,
   input  logic       i_clk_gen_done,
   output logic       o_sb_req_valid,
   output logic [1:0] o_sb_req_msg,
   input  logic       i_sb_req_ready,
   input  logic       i_sb_rsp_valid,
   input  logic [1:0] i_sb_rsp_msg,
   input  logic [2:0] i_sb_rsp_result,
   output logic       o_busy,
   output logic       o_pass,
   output logic       o_fail,
   output logic       o_timeout,
   output logic [2:0] o_result,
   output logic [3:0] o_retry_cnt
);

   state_t           r_state;
   state_t           w_next;
   logic [TMR_W-1:0] r_timer;
   logic [3:0]       r_retry;
   logic [2:0]       r_result;
   logic             r_timeout;
   logic             r_gen_stop;

   logic w_req_valid;
   logic w_tmo;
   logic w_rsp_hit;
   logic w_accept;
   logic w_tmo_fail;
   logic w_eval_retry;
   logic w_capture;
   logic w_load;
   logic w_timed;
   logic w_change;

   assign w_tmo     = (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
   assign w_rsp_hit = i_sb_rsp_valid && (i_sb_rsp_msg == state_msg(r_state));
   assign w_accept  = w_req_valid && i_sb_req_ready;
   assign w_change  = (w_next != r_state);
   assign w_timed   = (r_state inside {ST_SEND_START, ST_WAIT_START, ST_PATTERN,
                                       ST_SEND_RESULT, ST_WAIT_RESULT,
                                       ST_SEND_DONE, ST_WAIT_DONE});
   assign w_load    = w_change && (w_next inside {ST_SEND_START, ST_SEND_RESULT, ST_SEND_DONE});

   // A normal exit (accept/response/done) is tested before the timer, so it wins a tie
   always_comb begin
      w_next       = r_state;
      w_tmo_fail   = 1'b0;
      w_eval_retry = 1'b0;
      w_capture    = 1'b0;
      if (i_ltsm_in_reset) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:        if (i_enable) w_next = ST_SEND_START;
            ST_SEND_START:  if (w_accept) w_next = ST_WAIT_START;
                            else if (w_tmo) w_tmo_fail = 1'b1;
            ST_WAIT_START:  if (w_rsp_hit) w_next = ST_PATTERN;
                            else if (w_tmo) w_tmo_fail = 1'b1;
            ST_PATTERN:     if (i_clk_gen_done) w_next = ST_SEND_RESULT;
                            else if (w_tmo) w_tmo_fail = 1'b1;
            ST_SEND_RESULT: if (w_accept) w_next = ST_WAIT_RESULT;
                            else if (w_tmo) w_tmo_fail = 1'b1;
            ST_WAIT_RESULT: if (w_rsp_hit) begin
                               w_next    = ST_EVAL;
                               w_capture = 1'b1;
                            end else if (w_tmo) w_tmo_fail = 1'b1;
            ST_EVAL:        if (r_result == RESULT_ALL_PASS) w_next = ST_SEND_DONE;
                            else if (r_retry < 4'(MAX_RETRY)) begin
                               w_next       = ST_SEND_START;
                               w_eval_retry = 1'b1;
                            end else w_next = ST_FAIL;
            ST_SEND_DONE:   if (w_accept) w_next = ST_WAIT_DONE;
                            else if (w_tmo) w_tmo_fail = 1'b1;
            ST_WAIT_DONE:   if (w_rsp_hit) w_next = ST_PASS;
                            else if (w_tmo) w_tmo_fail = 1'b1;
            ST_PASS,
            ST_FAIL:        if (!i_enable) w_next = ST_IDLE;
            default:        w_next = ST_IDLE;
         endcase
         if (w_tmo_fail) w_next = ST_FAIL;
      end
   end

   always_ff @(posedge i_dig_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_retry    <= '0;
         r_result   <= '0;
         r_timeout  <= 1'b0;
         r_gen_stop <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_timer    <= (w_change || !w_timed) ? '0 : r_timer + 1'b1;
         r_gen_stop <= (i_ltsm_in_reset && r_state != ST_IDLE) || w_eval_retry ||
                       (w_next == ST_FAIL && r_state != ST_FAIL);
         if (r_state == ST_IDLE && w_next == ST_SEND_START) begin
            r_retry   <= '0;
            r_result  <= '0;
            r_timeout <= 1'b0;
         end
         if (w_capture)    r_result  <= i_sb_rsp_result;
         if (w_eval_retry) r_retry   <= r_retry + 1'b1;
         if (w_tmo_fail)   r_timeout <= 1'b1;
      end
   end

   clk_train_sequencer_sb_req_holder u_sb_req_holder (
      .i_clk   (i_dig_clk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_msg   (state_msg(w_next)),
      .i_drop  (w_change),
      .i_ready (i_sb_req_ready),
      .o_valid (w_req_valid),
      .o_msg   (o_sb_req_msg)
   );

   // Timer is zero only in the first cycle of PATTERN, giving a one-cycle start pulse
   assign o_start_clk_train = (r_state == ST_PATTERN) && (r_timer == '0);
   assign o_gen_stop        = r_gen_stop;
   assign o_sb_req_valid    = w_req_valid;
   assign o_busy            = !(r_state inside {ST_IDLE, ST_PASS, ST_FAIL});
   assign o_pass            = (r_state == ST_PASS);
   assign o_fail            = (r_state == ST_FAIL);
   assign o_timeout         = r_timeout;
   assign o_result          = r_result;
   assign o_retry_cnt       = r_retry;

endmodule

// File: tb/tb_clk_train_sequencer.sv
// Directed bench for clk_train_sequencer: clean pass, retries, exhaustion,
// timeout edge, backpressure/wrong message and LTSM abort.
module tb_clk_train_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic       abort = 1'b0;
   logic       start_pulse;
   logic       gen_stop;
   logic       gen_done = 1'b0;
   logic       req_valid;
   logic [1:0] req_msg;
   logic       req_ready = 1'b0;
   logic       rsp_valid = 1'b0;
   logic [1:0] rsp_msg = 2'b00;
   logic [2:0] rsp_result = 3'b000;
   logic       busy, pass, fail, timeout;
   logic [2:0] result;
   logic [3:0] retry_cnt;

   int total = 0;
   int bad   = 0;
   int n_start = 0;
   int n_stop  = 0;
   int s0, g0;

   localparam logic [1:0] START = 2'b01;
   localparam logic [1:0] RES   = 2'b10;
   localparam logic [1:0] DONE  = 2'b11;

   clk_train_sequencer #(.TIMEOUT_CYCLES(1000), .MAX_RETRY(3), .TMR_W(10)) dut (
      .i_dig_clk        (clk),
      .i_rst            (rst),
      .i_enable         (enable),
      .i_ltsm_in_reset  (abort),
      .o_start_clk_train(start_pulse),
      .o_gen_stop       (gen_stop),
      .i_clk_gen_done   (gen_done),
      .o_sb_req_valid   (req_valid),
      .o_sb_req_msg     (req_msg),
      .i_sb_req_ready   (req_ready),
      .i_sb_rsp_valid   (rsp_valid),
      .i_sb_rsp_msg     (rsp_msg),
      .i_sb_rsp_result  (rsp_result),
      .o_busy           (busy),
      .o_pass           (pass),
      .o_fail           (fail),
      .o_timeout        (timeout),
      .o_result         (result),
      .o_retry_cnt      (retry_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (start_pulse) n_start <= n_start + 1;
      if (gen_stop)    n_stop  <= n_stop + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_req(input logic [1:0] msg);
      int n = 0;
      while (!req_valid && n < 100) begin
         step();
         n++;
      end
      chk("req_valid", req_valid, 1);
      chk("req_msg", req_msg, msg);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
   endtask

   task automatic send_rsp(input logic [1:0] msg, input logic [2:0] res);
      rsp_valid  = 1'b1;
      rsp_msg    = msg;
      rsp_result = res;
      step();
      rsp_valid  = 1'b0;
   endtask

   task automatic run_pattern(input logic [2:0] res);
      int n = 0;
      wait_req(START);
      send_rsp(START, 3'b000);
      while (!start_pulse && n < 20) begin
         step();
         n++;
      end
      chk("start_pulse", start_pulse, 1);
      step(193);
      gen_done = 1'b1;
      step();
      gen_done = 1'b0;
      wait_req(RES);
      send_rsp(RES, res);
   endtask

   task automatic finish_done();
      wait_req(DONE);
      send_rsp(DONE, 3'b000);
   endtask

   task automatic go_idle();
      enable = 1'b0;
      step(2);
   endtask

   initial begin
      int stable;
      // reset
      step(3);
      chk("rst_busy", busy, 0);
      chk("rst_pass", pass, 0);
      chk("rst_fail", fail, 0);
      chk("rst_tmo", timeout, 0);
      chk("rst_valid", req_valid, 0);
      chk("rst_msg", req_msg, 0);
      chk("rst_result", result, 0);
      chk("rst_retry", retry_cnt, 0);
      rst = 1'b0;
      step();

      // clean pass
      s0 = n_start; g0 = n_stop;
      enable = 1'b1;
      step();
      chk("clean_busy", busy, 1);
      run_pattern(3'b111);
      finish_done();
      chk("clean_pass", pass, 1);
      chk("clean_busy_done", busy, 0);
      chk("clean_retry", retry_cnt, 0);
      chk("clean_nstart", n_start - s0, 1);
      chk("clean_nstop", n_stop - g0, 0);
      go_idle();
      chk("clean_idle", pass, 0);

      // retry then pass
      s0 = n_start; g0 = n_stop;
      enable = 1'b1;
      run_pattern(3'b101);
      run_pattern(3'b011);
      run_pattern(3'b111);
      finish_done();
      chk("retry_pass", pass, 1);
      chk("retry_cnt", retry_cnt, 2);
      chk("retry_result", result, 3'b111);
      chk("retry_nstart", n_start - s0, 3);
      chk("retry_nstop", n_stop - g0, 2);
      go_idle();

      // retry exhaustion
      s0 = n_start;
      enable = 1'b1;
      for (int i = 0; i < 4; i++) run_pattern(3'b000);
      step(2);
      chk("exh_fail", fail, 1);
      chk("exh_tmo", timeout, 0);
      chk("exh_retry", retry_cnt, 3);
      chk("exh_nstart", n_start - s0, 4);
      chk("exh_result", result, 3'b000);
      go_idle();
      chk("exh_idle", fail, 0);

      // timeout in WAIT_START
      enable = 1'b1;
      wait_req(START);
      step(999);
      chk("tmo_edge_fail", fail, 0);
      step();
      chk("tmo_fail", fail, 1);
      chk("tmo_flag", timeout, 1);
      go_idle();
      chk("tmo_sticky", timeout, 1);
      enable = 1'b1;
      step();
      chk("tmo_cleared", timeout, 0);
      wait_req(START);
      step(999);
      send_rsp(START, 3'b000);
      chk("tmo_last_rsp", start_pulse, 1);
      chk("tmo_last_nofail", fail, 0);

      // abort mid-PATTERN, overriding done and enable
      step(10);
      g0 = n_stop;
      abort = 1'b1; gen_done = 1'b1; enable = 1'b0;
      step();
      abort = 1'b0; gen_done = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_valid", req_valid, 0);
      chk("abort_stop", gen_stop, 1);
      chk("abort_nopass", pass, 0);
      chk("abort_nofail", fail, 0);
      step(3);
      chk("abort_nstop", n_stop - g0, 1);

      // backpressure and wrong message
      enable = 1'b1;
      step();
      stable = 0;
      for (int i = 0; i < 20; i++) begin
         if (req_valid && req_msg == START) stable++;
         step();
      end
      chk("bp_stable", stable, 20);
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      chk("bp_drop", req_valid, 0);
      send_rsp(DONE, 3'b000);
      chk("wrong_msg_nostart", start_pulse, 0);
      chk("wrong_msg_busy", busy, 1);
      send_rsp(START, 3'b000);
      chk("right_msg_start", start_pulse, 1);

      // reset together with abort: no stop pulse
      rst = 1'b1; abort = 1'b1; enable = 1'b0;
      step();
      rst = 1'b0; abort = 1'b0;
      chk("rst_abort_stop", gen_stop, 0);
      chk("rst_abort_busy", busy, 0);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
